// File: rtl/mod_controller_bank_pkg.sv
// Shared types for the multi-port serial controller reader.
package mod_controller_bank_pkg;

  // Scan sequencer states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LATCH    = 3'd1,
    ST_PULSE_LO = 3'd2,
    ST_PULSE_HI = 3'd3,
    ST_COMMIT   = 3'd4
  } state_t;

  // NES button positions within one port's slice of out_buttons
  typedef enum logic [2:0] {
    NES_A      = 3'd0,
    NES_B      = 3'd1,
    NES_SELECT = 3'd2,
    NES_START  = 3'd3,
    NES_UP     = 3'd4,
    NES_DOWN   = 3'd5,
    NES_LEFT   = 3'd6,
    NES_RIGHT  = 3'd7
  } nes_button_t;

  // SNES button positions within one port's slice of out_buttons
  typedef enum logic [3:0] {
    SNES_B      = 4'd0,
    SNES_Y      = 4'd1,
    SNES_SELECT = 4'd2,
    SNES_START  = 4'd3,
    SNES_UP     = 4'd4,
    SNES_DOWN   = 4'd5,
    SNES_LEFT   = 4'd6,
    SNES_RIGHT  = 4'd7,
    SNES_A      = 4'd8,
    SNES_X      = 4'd9,
    SNES_L      = 4'd10,
    SNES_R      = 4'd11
  } snes_button_t;

endpackage

// File: rtl/mod_sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
module mod_sync_edge (
  input  logic in_clk,
  input  logic in_reset,
  input  logic in_async,
  output logic out_rise
);

  // [0] metastable stage, [1] synchronised, [2] previous synchronised value
  logic [2:0] sync_q;

  // Shift the async input in and flag a 0->1 transition for one cycle
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      sync_q   <= '0;
      out_rise <= 1'b0;
    end else begin
      sync_q   <= {sync_q[1:0], in_async};
      out_rise <= sync_q[1] & ~sync_q[2];
    end
  end

endmodule

// File: rtl/mod_controller_bank.sv
// NES/SNES serial pad reader: scans NUM_PORTS pads per frame over a shared
// latch/pulse pair and publishes held state plus per-frame edge events.
module mod_controller_bank
  import mod_controller_bank_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned NUM_BITS  = 8,
  parameter int unsigned CLK_DIV   = 256
) (
  input  logic                           in_clk,
  input  logic                           in_reset,
  input  logic                           in_vsync,
  input  logic                           in_auto,
  input  logic [NUM_PORTS-1:0]           in_controller_data,
  output logic                           out_controller_latch,
  output logic                           out_controller_pulse,
  output logic [NUM_PORTS*NUM_BITS-1:0]  out_buttons,
  output logic [NUM_PORTS*NUM_BITS-1:0]  out_pressed,
  output logic [NUM_PORTS*NUM_BITS-1:0]  out_released,
  output logic                           out_valid,
  output logic                           out_overrun
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(NUM_BITS + 1);

  state_t                                state;
  logic [CNT_W-1:0]                      div_cnt;
  logic                                  latch_half;
  logic [BIT_W-1:0]                      bit_idx;
  logic [NUM_PORTS-1:0][NUM_BITS-1:0]    shadow;
  logic [NUM_PORTS-1:0][NUM_BITS-1:0]    shadow_nxt_c;
  logic                                  vs_rise;
  logic                                  div_done_c;
  logic                                  sample_c;
  logic                                  last_bit_c;

  // Frame trigger crossing from the VGA domain
  mod_sync_edge u_vsync_edge (
    .in_clk   (in_clk),
    .in_reset (in_reset),
    .in_async (in_vsync),
    .out_rise (vs_rise)
  );

  // Divider terminal count, sample strobe and the shadow with the next bit shifted in.
  // Bits arrive LSB first, so each port shifts right with the new bit entering at the MSB.
  always_comb begin
    div_done_c   = (div_cnt == CNT_W'(CLK_DIV - 1));
    sample_c     = div_done_c && (((state == ST_LATCH) && latch_half) || (state == ST_PULSE_HI));
    last_bit_c   = (bit_idx == BIT_W'(NUM_BITS - 1));
    shadow_nxt_c = shadow;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      shadow_nxt_c[p] = {~in_controller_data[p], shadow[p][NUM_BITS-1:1]};
    end
  end

  // Scan sequencer with registered latch/pulse and commit outputs
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state                <= ST_IDLE;
      div_cnt              <= '0;
      latch_half           <= 1'b0;
      bit_idx              <= '0;
      shadow               <= '0;
      out_controller_latch <= 1'b0;
      out_controller_pulse <= 1'b0;
      out_buttons          <= '0;
      out_pressed          <= '0;
      out_released         <= '0;
      out_valid            <= 1'b0;
      out_overrun          <= 1'b0;
    end else begin
      out_valid    <= 1'b0;
      out_pressed  <= '0;
      out_released <= '0;

      // A trigger that cannot start a scan is lost; only meaningful in vsync mode
      if (vs_rise && !in_auto && (state != ST_IDLE)) begin
        out_overrun <= 1'b1;
      end

      div_cnt <= div_done_c ? '0 : div_cnt + CNT_W'(1);

      case (state)
        ST_IDLE: begin
          div_cnt <= '0;
          if (in_auto || vs_rise) begin
            state                <= ST_LATCH;
            out_controller_latch <= 1'b1;
            latch_half           <= 1'b0;
            bit_idx              <= '0;
          end
        end
        ST_LATCH: begin
          // Latch spans two divider periods
          if (div_done_c) begin
            latch_half <= 1'b1;
          end
        end
        ST_PULSE_LO: begin
          if (div_done_c) begin
            state                <= ST_PULSE_HI;
            out_controller_pulse <= 1'b1;
          end
        end
        ST_PULSE_HI: begin
        end
        ST_COMMIT: begin
          div_cnt <= '0;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      // End of LATCH or PULSE_HI: capture one bit from every port
      if (sample_c) begin
        shadow               <= shadow_nxt_c;
        out_controller_latch <= 1'b0;
        out_controller_pulse <= 1'b0;
        if (last_bit_c) begin
          state        <= ST_COMMIT;
          out_buttons  <= shadow_nxt_c;
          out_pressed  <= shadow_nxt_c & ~out_buttons;
          out_released <= ~shadow_nxt_c & out_buttons;
          out_valid    <= 1'b1;
        end else begin
          state   <= ST_PULSE_LO;
          bit_idx <= bit_idx + BIT_W'(1);
        end
      end
    end
  end

endmodule
